// File: rtl/signal_alarm_monitor_if.sv
// Sample/control bundle between the bench or upstream monitor and the alarm stage.
// master drives sample_en/control_in/status_in/threshold/clear_alarm; slave returns
// alarm/warn/state_out/peak_value/event_count. CNT_W must match the monitor's CNT_W.
interface signal_alarm_monitor_if #(
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic [3:0]       control_in;
  logic [2:0]       status_in;
  logic [3:0]       threshold;
  logic             clear_alarm;
  logic             alarm;
  logic             warn;
  logic [1:0]       state_out;
  logic [3:0]       peak_value;
  logic [CNT_W-1:0] event_count;

  modport master (
    output sample_en, control_in, status_in,
    output threshold, clear_alarm,
    input  alarm, warn, state_out,
    input  peak_value, event_count
  );

  modport slave (
    input  sample_en, control_in, status_in,
    input  threshold, clear_alarm,
    output alarm, warn, state_out,
    output peak_value, event_count
  );
endinterface

// File: rtl/signal_alarm_monitor.sv
// Debounced threshold alarm on the upstream control value, with peak and trip count.
// Ports: clk, reset (sync, active-high), bus (slave: sample inputs in, alarm status out).
// Build option: ALARM_LATCH_EN keeps the alarm set in RELEASE until clear/reset.
module signal_alarm_monitor #(
  parameter int TRIP_COUNT    = 3,
  parameter int RELEASE_COUNT = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  signal_alarm_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WATCH   = 2'b01,
    ALARM   = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int RW = $clog2(TRIP_COUNT + 1);
  localparam int LW = $clog2(RELEASE_COUNT + 1);
  localparam logic [RW-1:0] TRIP_L = RW'(TRIP_COUNT);
  localparam logic [LW-1:0] REL_L  = LW'(RELEASE_COUNT);
  localparam logic [CNT_W-1:0] EV_MAX = '1;

  state_t           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [LW-1:0]    rel_q, rel_d;
  logic [3:0]       peak_q, peak_d;
  logic [CNT_W-1:0] evt_q, evt_d;

  logic valid, over, under;

  // status 111 marks upstream test/average samples: not real data
  always_comb begin
    valid = bus.sample_en && (bus.status_in != 3'b111);
    over  = valid && (bus.threshold != 4'd0) &&
            (bus.control_in >= bus.threshold);
    under = valid && !over;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rel_d   = rel_q;
    peak_d  = peak_q;
    evt_d   = evt_q;
    if (bus.clear_alarm) begin
      state_d = IDLE;
      run_d   = '0;
      rel_d   = '0;
      peak_d  = '0;
    end else begin
      if (valid && (bus.control_in > peak_q))
        peak_d = bus.control_in;
      unique case (state_q)
        IDLE: begin
          if (over) begin
            if (TRIP_COUNT == 1) begin
              state_d = ALARM;
              run_d   = '0;
            end else begin
              state_d = WATCH;
              run_d   = RW'(1);
            end
          end
        end
        WATCH: begin
          if (over) begin
            if (run_q + RW'(1) == TRIP_L) begin
              state_d = ALARM;
              run_d   = '0;
            end else begin
              run_d = run_q + RW'(1);
            end
          end else if (under) begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM: begin
          if (under) begin
`ifdef ALARM_LATCH_EN
            state_d = RELEASE;
            rel_d   = LW'(1);
`else
            if (RELEASE_COUNT == 1) begin
              state_d = IDLE;
              rel_d   = '0;
            end else begin
              state_d = RELEASE;
              rel_d   = LW'(1);
            end
`endif
          end
        end
        RELEASE: begin
          if (over) begin
            state_d = ALARM;
            rel_d   = '0;
          end else if (under) begin
`ifdef ALARM_LATCH_EN
            // latched: count saturates, only clear/reset leaves
            if (rel_q != REL_L)
              rel_d = rel_q + LW'(1);
`else
            if (rel_q + LW'(1) == REL_L) begin
              state_d = IDLE;
              rel_d   = '0;
            end else begin
              rel_d = rel_q + LW'(1);
            end
`endif
          end
        end
      endcase
      // only fresh trips count; RELEASE->ALARM is the same event
      if ((state_d == ALARM) &&
          ((state_q == IDLE) || (state_q == WATCH)) &&
          (evt_q != EV_MAX))
        evt_d = evt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      rel_q   <= '0;
      peak_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      rel_q   <= rel_d;
      peak_q  <= peak_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.alarm       = state_q[1];
  assign bus.warn        = (state_q == WATCH);
  assign bus.state_out   = state_q;
  assign bus.peak_value  = peak_q;
  assign bus.event_count = evt_q;

endmodule

// File: tb/tb_signal_alarm_monitor.sv
// Bench for signal_alarm_monitor: directed table, corner sequences, random vs model.
// Two instances: default params, and TRIP=1/RELEASE=1/CNT_W=2 for saturation.
module tb_signal_alarm_monitor;

`ifdef ALARM_LATCH_EN
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  signal_alarm_monitor_if #(.CNT_W(8)) if0 ();
  signal_alarm_monitor_if #(.CNT_W(2)) if1 ();

  signal_alarm_monitor #(
    .TRIP_COUNT(3), .RELEASE_COUNT(4), .CNT_W(8)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(if0)
  );

  signal_alarm_monitor #(
    .TRIP_COUNT(1), .RELEASE_COUNT(1), .CNT_W(2)
  ) u_sat (
    .clk(clk), .reset(reset), .bus(if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    bit alarm;
    int run;
    int rel;
    int peak;
    int ev;
  } m_t;

  m_t m0, m1;

  typedef struct {
    bit         en;
    logic [3:0] ctl;
    logic [2:0] st;
    logic [3:0] thr;
    bit         clr;
    int         est;
    int         epk;
    int         eev;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference: alarm flag plus run lengths of over/under samples.
  function automatic m_t mstep(m_t m, bit r, bit en, logic [3:0] ctl,
                               logic [2:0] st, logic [3:0] thr, bit clr,
                               int trip, int rc, int evmax);
    bit valid, over;
    if (r) begin
      m = '0;
      return m;
    end
    if (clr) begin
      m.alarm = 0; m.run = 0; m.rel = 0; m.peak = 0;
      return m;
    end
    valid = en && (st != 3'd7);
    if (!valid) return m;
    over = (thr != 0) && (int'(ctl) >= int'(thr));
    if (int'(ctl) > m.peak) m.peak = int'(ctl);
    if (!m.alarm) begin
      if (over) begin
        m.run++;
        if (m.run >= trip) begin
          m.alarm = 1; m.run = 0; m.rel = 0;
          if (m.ev < evmax) m.ev++;
        end
      end else begin
        m.run = 0;
      end
    end else if (over) begin
      m.rel = 0;
    end else begin
      m.rel++;
      if (LAT) begin
        if (m.rel > rc) m.rel = rc;
      end else if (m.rel >= rc) begin
        m.alarm = 0; m.rel = 0;
      end
    end
    return m;
  endfunction

  function automatic int mst(m_t m);
    if (!m.alarm) return (m.run == 0) ? 0 : 1;
    return (m.rel == 0) ? 2 : 3;
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, int st, int al, int wn, int pk, int ev,
                         int est, int epk, int eev);
    cmp({tag, ".state"}, st, est);
    cmp({tag, ".alarm"}, al, (est >= 2) ? 1 : 0);
    cmp({tag, ".warn"}, wn, (est == 1) ? 1 : 0);
    cmp({tag, ".peak"}, pk, epk);
    cmp({tag, ".events"}, ev, eev);
  endtask

  task automatic step(bit r, bit en, logic [3:0] ctl, logic [2:0] st,
                      logic [3:0] thr, bit clr);
    reset = r;
    if0.sample_en = en; if0.control_in = ctl; if0.status_in = st;
    if0.threshold = thr; if0.clear_alarm = clr;
    if1.sample_en = en; if1.control_in = ctl; if1.status_in = st;
    if1.threshold = thr; if1.clear_alarm = clr;
    @(posedge clk);
    #1;
    m0 = mstep(m0, r, en, ctl, st, thr, clr, 3, 4, 255);
    m1 = mstep(m1, r, en, ctl, st, thr, clr, 1, 1, 3);
    chk_all("m0", int'(if0.state_out), int'(if0.alarm), int'(if0.warn),
            int'(if0.peak_value), int'(if0.event_count),
            mst(m0), m0.peak, m0.ev);
    chk_all("m1", int'(if1.state_out), int'(if1.alarm), int'(if1.warn),
            int'(if1.peak_value), int'(if1.event_count),
            mst(m1), m1.peak, m1.ev);
  endtask

  function automatic void add(bit en, logic [3:0] ctl, logic [2:0] st,
                              logic [3:0] thr, bit clr,
                              int est, int epk, int eev);
    vec_t v;
    v.en = en; v.ctl = ctl; v.st = st; v.thr = thr; v.clr = clr;
    v.est = est; v.epk = epk; v.eev = eev;
    vq.push_back(v);
  endfunction

  initial begin
    logic [3:0] thr_v;
    int rl;
    m0 = '0;
    m1 = '0;
    rl = LAT ? 3 : 0;

    // trip on 9,9,9 then release on 2,2,2,2
    add(1, 9, 0, 8, 0, 1, 9, 1 - 1);
    add(1, 9, 0, 8, 0, 1, 9, 0);
    add(1, 9, 0, 8, 0, 2, 9, 1);
    add(1, 2, 0, 8, 0, 3, 9, 1);
    add(1, 2, 0, 8, 0, 3, 9, 1);
    add(1, 2, 0, 8, 0, 3, 9, 1);
    add(1, 2, 0, 8, 0, rl, 9, 1);
    add(0, 0, 0, 8, 1, 0, 0, 1);
    // test-mode samples are ignored
    for (int i = 0; i < 10; i++) add(1, 15, 7, 8, 0, 0, 0, 1);
    // broken run
    add(1, 9, 0, 8, 0, 1, 9, 1);
    add(1, 9, 0, 8, 0, 1, 9, 1);
    add(1, 5, 0, 8, 0, 0, 9, 1);
    // clear beats the third over sample
    add(1, 9, 0, 8, 0, 1, 9, 1);
    add(1, 9, 0, 8, 0, 1, 9, 1);
    add(1, 9, 0, 8, 1, 0, 0, 1);
    // equality trips, invalid cycles hold, threshold changes
    add(1, 8, 0, 8, 0, 1, 8, 1);
    add(0, 15, 0, 8, 0, 1, 8, 1);
    add(1, 15, 7, 8, 0, 1, 8, 1);
    add(1, 8, 0, 8, 0, 1, 8, 1);
    add(1, 10, 0, 8, 0, 2, 10, 2);
    add(1, 15, 0, 0, 0, 3, 15, 2);
    add(1, 12, 0, 13, 0, 3, 15, 2);
    add(1, 13, 0, 13, 0, 2, 15, 2);
    add(1, 1, 0, 13, 0, 3, 15, 2);
    add(1, 1, 0, 13, 0, 3, 15, 2);
    add(1, 1, 0, 13, 0, 3, 15, 2);
    add(1, 1, 0, 13, 0, rl, 15, 2);
    add(0, 0, 0, 8, 1, 0, 0, 2);

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 4'($urandom), 3'($urandom),
           4'($urandom), 1'($urandom));
    chk_all("reset", int'(if0.state_out), int'(if0.alarm), int'(if0.warn),
            int'(if0.peak_value), int'(if0.event_count), 0, 0, 0);

    foreach (vq[i]) begin
      step(0, vq[i].en, vq[i].ctl, vq[i].st, vq[i].thr, vq[i].clr);
      chk_all($sformatf("vec%0d", i), int'(if0.state_out),
              int'(if0.alarm), int'(if0.warn), int'(if0.peak_value),
              int'(if0.event_count), vq[i].est, vq[i].epk, vq[i].eev);
    end

    // single-sample trip/release and 2-bit event saturation
    step(1, 0, 0, 0, 15, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 15, 0, 15, 0);
      cmp("sat.state", int'(if1.state_out), 2);
      cmp("sat.events", int'(if1.event_count), (i + 1 > 3) ? 3 : i + 1);
      step(0, 1, 0, 0, 15, 0);
      cmp("sat.release", int'(if1.state_out), LAT ? 3 : 0);
      step(0, 0, 0, 0, 15, 1);
      cmp("sat.clear", int'(if1.state_out), 0);
    end

    // mid-run reset
    step(0, 1, 15, 0, 15, 0);
    step(1, 1, 15, 0, 15, 0);
    chk_all("midreset", int'(if0.state_out), int'(if0.alarm), int'(if0.warn),
            int'(if0.peak_value), int'(if0.event_count), 0, 0, 0);

    // random stimulus against the model
    thr_v = 4'd8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) thr_v = 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 4) != 0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
           thr_v,
           $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
